// File: rtl/video_pkg.sv
// video_pkg: constants and FSM encoding shared by the video fetch path.
// Provides the byte slice width, fetch FSM states and default frame size.
package video_pkg;

    localparam int SLICE_WIDTH     = 8;
    localparam int FRAME_BYTES_DEF = 19200;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        LOAD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_addr_gen.sv
// fetch_addr_gen: frame-memory byte address counter wrapping at FRAME_BYTES.
// Ports: clk/rst, inc (advance), clr (restart at 0), addr, frame_done pulse.
module fetch_addr_gen
    import video_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_done
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              frame_done_q;
    logic              frame_done_d;
    logic              last;

    assign last = (addr_q == ADDR_W'(FRAME_BYTES - 1));

    // clr wins over inc so a restart never reports a finished frame
    always_comb begin
        addr_d       = addr_q;
        frame_done_d = 1'b0;
        if (clr) begin
            addr_d = '0;
        end else if (inc) begin
            frame_done_d = last;
            addr_d       = last ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign addr       = addr_q;
    assign frame_done = frame_done_q;

endmodule

// File: rtl/video_fetch.sv
// video_fetch: reads pixel bytes from frame memory and packs BSIZE of them
// into one word, strobed into the pixel line buffer with a load pulse.
// Ports: clk25MHz/rst, en, frame_start, full/watermark_on from the buffer,
// data/load to the buffer, mem_rd/mem_addr/mem_rdata(_valid) to memory,
// frame_done when the last frame byte is accepted.
module video_fetch
    import video_pkg::*;
#(
    parameter int BSIZE       = 2,
    parameter int ADDR_W      = 15,
    parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
    input  logic                         clk25MHz,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         frame_start,
    input  logic                         full,
    input  logic                         watermark_on,
    output logic [BSIZE*SLICE_WIDTH-1:0] data,
    output logic                         load,
    output logic                         mem_rd,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [SLICE_WIDTH-1:0]       mem_rdata,
    input  logic                         mem_rdata_valid,
    output logic                         frame_done
);

    localparam int DW    = BSIZE * SLICE_WIDTH;
    localparam int CNT_W = $clog2(BSIZE + 1);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [DW-1:0]    pack_q;
    logic [DW-1:0]    pack_d;
    logic [DW-1:0]    data_q;
    logic [DW-1:0]    data_d;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [CNT_W-1:0] byte_cnt_d;
    logic             load_q;
    logic             load_d;
    logic             mem_rd_q;
    logic             mem_rd_d;
    logic             take;
    logic             last_byte;
    logic             trigger;
    logic             addr_inc;

    assign take      = (state_q == WAIT) && mem_rdata_valid;
    assign last_byte = (byte_cnt_q == CNT_W'(BSIZE - 1));
    assign trigger   = en && (!full || watermark_on);

    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // REQ and LOAD are left only once their strobe has actually been
    // issued; with en low they park until the strobe can go out.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!frame_start && trigger) state_d = REQ;
            end
            REQ: begin
                if (frame_start)   state_d = IDLE;
                else if (mem_rd_q) state_d = WAIT;
            end
            WAIT: begin
                if (frame_start) begin
                    state_d = mem_rdata_valid ? IDLE : DRAIN;
                end else if (mem_rdata_valid) begin
                    state_d = last_byte ? LOAD : REQ;
                end
            end
            LOAD: begin
                if (frame_start || load_q) state_d = IDLE;
            end
            DRAIN: begin
                if (mem_rdata_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        addr_inc   = 1'b0;
        if (frame_start) begin
            pack_d     = '0;
            byte_cnt_d = '0;
        end else if (take) begin
            pack_d     = (pack_q << SLICE_WIDTH) | DW'(mem_rdata);
            byte_cnt_d = last_byte ? '0 : byte_cnt_q + CNT_W'(1);
            addr_inc   = 1'b1;
        end
        // strobes are registered on entry so they coincide with the state
        mem_rd_d = (state_d == REQ) && en;
        load_d   = (state_d == LOAD) && en;
        data_d   = load_d ? pack_d : data_q;
    end

    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst) begin
            pack_q     <= '0;
            data_q     <= '0;
            byte_cnt_q <= '0;
            load_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
        end else begin
            pack_q     <= pack_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            load_q     <= load_d;
            mem_rd_q   <= mem_rd_d;
        end
    end

    fetch_addr_gen #(
        .ADDR_W      (ADDR_W),
        .FRAME_BYTES (FRAME_BYTES)
    ) u_addr (
        .clk        (clk25MHz),
        .rst        (rst),
        .inc        (addr_inc),
        .clr        (frame_start),
        .addr       (mem_addr),
        .frame_done (frame_done)
    );

    assign data   = data_q;
    assign load   = load_q;
    assign mem_rd = mem_rd_q;

endmodule

// File: tb/tb_video_fetch.sv
// tb_video_fetch: scoreboard bench for video_fetch with a latency-
// programmable single-outstanding memory model and a short frame.
module tb_video_fetch;
    import video_pkg::*;

    localparam int BSIZE       = 2;
    localparam int ADDR_W      = 15;
    localparam int FRAME_BYTES = 21;
    localparam int DW          = BSIZE * 8;

    logic              clk25MHz = 1'b0;
    logic              rst;
    logic              en;
    logic              frame_start;
    logic              full;
    logic              watermark_on;
    logic [DW-1:0]     data;
    logic              load;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;
    logic              mem_rdata_valid = 1'b0;
    logic              frame_done;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int load_cnt = 0;
    int fd_cnt = 0;
    int lat = 1;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [DW-1:0]     exp_data[$];

    always #20 clk25MHz = ~clk25MHz;

    video_fetch #(
        .BSIZE       (BSIZE),
        .ADDR_W      (ADDR_W),
        .FRAME_BYTES (FRAME_BYTES)
    ) dut (
        .clk25MHz        (clk25MHz),
        .rst             (rst),
        .en              (en),
        .frame_start     (frame_start),
        .full            (full),
        .watermark_on    (watermark_on),
        .data            (data),
        .load            (load),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .frame_done      (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        if (a == 0) return 8'hA5;
        if (a == 1) return 8'h3C;
        return 8'(32'(a) * 37 + 5);
    endfunction

    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a);
        return (32'(a) == FRAME_BYTES - 1) ? '0 : a + ADDR_W'(1);
    endfunction

    task automatic push_word(input logic [ADDR_W-1:0] a);
        exp_addr.push_back(a);
        exp_addr.push_back(nxt(a));
        exp_data.push_back({mem_byte(a), mem_byte(nxt(a))});
    endtask

    // memory: a request seen at edge e answers so the DUT samples at e+lat
    logic              pend = 1'b0;
    int                lcnt = 0;
    logic [ADDR_W-1:0] paddr = '0;
    always @(posedge clk25MHz) begin
        mem_rdata_valid <= 1'b0;
        if (pend) begin
            if (lcnt <= 1) begin
                mem_rdata_valid <= 1'b1;
                mem_rdata       <= mem_byte(paddr);
                pend            <= 1'b0;
            end else begin
                lcnt <= lcnt - 1;
            end
        end
        if (mem_rd) begin
            if (lat <= 1) begin
                mem_rdata_valid <= 1'b1;
                mem_rdata       <= mem_byte(mem_addr);
            end else begin
                pend  <= 1'b1;
                lcnt  <= lat - 1;
                paddr <= mem_addr;
            end
        end
    end

    always @(negedge clk25MHz) begin
        if (!rst) begin
            if (mem_rd) begin
                rd_cnt++;
                if (exp_addr.size() == 0) check("rd_extra", 32'(mem_addr), 32'hFFFF);
                else check("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            end
            if (load) begin
                load_cnt++;
                if (exp_data.size() == 0) check("load_extra", 32'(data), 32'hFFFFF);
                else check("load_data", 32'(data), 32'(exp_data.pop_front()));
            end
            if (frame_done) begin
                fd_cnt++;
                check("fd_addr", 32'(mem_addr), 32'd0);
            end
        end
    end

    task automatic step();
        @(negedge clk25MHz);
        #1;
    endtask

    task automatic wait_load(input int target, input string tag);
        int n = 0;
        while (load_cnt < target && n < 300) begin
            step();
            n++;
        end
        if (load_cnt < target) check(tag, 32'(load_cnt), 32'(target));
    endtask

    task automatic wait_rd(input int target, input string tag);
        int n = 0;
        while (rd_cnt < target && n < 300) begin
            step();
            n++;
        end
        if (rd_cnt < target) check(tag, 32'(rd_cnt), 32'(target));
    endtask

    initial begin
        int n;
        int r0;
        int l0;
        rst = 1'b1;
        en = 1'b1;
        frame_start = 1'b0;
        full = 1'b1;
        watermark_on = 1'b0;
        repeat (3) step();
        check("rst_data", 32'(data), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);

        // first word: request next cycle, load BSIZE*(1+L) cycles later
        rst = 1'b0;
        push_word(0);
        full = 1'b0;
        n = 0;
        while (load_cnt < 1 && n < 20) begin
            step();
            n++;
            if (n == 1) check("t1_rd_next", 32'(rd_cnt), 32'd1);
        end
        check("t1_load_lat", 32'(n), 32'd5);
        full = 1'b1;
        step();

        // full and not low: no traffic; watermark starts fetch at once
        r0 = rd_cnt;
        repeat (50) step();
        check("t2_no_rd", 32'(rd_cnt - r0), 32'd0);
        check("t2_no_load", 32'(load_cnt), 32'd1);
        push_word(2);
        watermark_on = 1'b1;
        step();
        check("t2_rd_next", 32'(rd_cnt - r0), 32'd1);
        wait_load(2, "t2_timeout");
        watermark_on = 1'b0;
        repeat (3) step();

        // run to the end of frame; last word straddles the wrap
        for (int a = 4; a <= 20; a += 2) push_word(ADDR_W'(a));
        full = 1'b0;
        wait_load(11, "t3_timeout");
        full = 1'b1;
        repeat (3) step();
        check("t3_fd_cnt", 32'(fd_cnt), 32'd1);
        check("t3_addr", 32'(mem_addr), 32'd1);

        // frame restart while a slow read is outstanding
        lat = 4;
        exp_addr.push_back(ADDR_W'(1));
        r0 = rd_cnt;
        full = 1'b0;
        wait_rd(r0 + 1, "t4_rd_timeout");
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("t4_drain", 32'(dut.state_q), 32'(DRAIN));
        push_word(0);
        wait_load(12, "t4_timeout");
        full = 1'b1;
        repeat (3) step();
        check("t4_loads", 32'(load_cnt), 32'd12);

        // enable dropped before the final byte lands: load is withheld
        push_word(2);
        r0 = rd_cnt;
        l0 = load_cnt;
        full = 1'b0;
        wait_rd(r0 + 2, "t5_rd_timeout");
        step();
        en = 1'b0;
        full = 1'b1;
        repeat (10) step();
        check("t5_held", 32'(load_cnt), 32'(l0));
        check("t5_state", 32'(dut.state_q), 32'(LOAD));
        check("t5_data_hold", 32'(data), 32'hA53C);
        en = 1'b1;
        wait_load(l0 + 1, "t5_timeout");
        repeat (4) step();
        check("t5_single", 32'(load_cnt), 32'(l0 + 1));

        // reset in the middle of a read; the late response is stray
        exp_addr.push_back(ADDR_W'(4));
        r0 = rd_cnt;
        l0 = load_cnt;
        full = 1'b0;
        wait_rd(r0 + 1, "t6_rd_timeout");
        step();
        rst = 1'b1;
        #1;
        check("t6_data", 32'(data), 32'd0);
        check("t6_addr", 32'(mem_addr), 32'd0);
        check("t6_rd", 32'(mem_rd), 32'd0);
        check("t6_load", 32'(load), 32'd0);
        check("t6_state", 32'(dut.state_q), 32'(IDLE));
        step();
        step();
        rst = 1'b0;
        push_word(0);
        wait_load(l0 + 1, "t6_timeout");
        full = 1'b1;
        repeat (12) step();
        check("t6_loads", 32'(load_cnt), 32'(l0 + 1));
        check("end_addr_q", 32'(exp_addr.size()), 32'd0);
        check("end_data_q", 32'(exp_data.size()), 32'd0);
        check("end_fd_cnt", 32'(fd_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_fetch.md
# video_fetch

Producer side of the pixel line buffer: fetches pixel bytes from frame memory over a single-outstanding request/valid read port and packs `BSIZE` bytes into one wide word. Presents that word with a one-cycle `load` pulse whenever the downstream buffer reports empty (`full`=0) or low (`watermark_on`=1). Sits between the frame-memory arbiter and the VGA pixel buffer, in the `clk25MHz` domain.

## Interface
- `BSIZE`, 2, bytes per packed word; range 1–8.
- `ADDR_W`, 15, frame-memory byte-address width.
- `FRAME_BYTES`, 19200, bytes per frame (160×120 × 8 bpp); must be ≤ 2^ADDR_W.
- `clk25MHz`  in  1  pixel clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  fetch enable; low blocks new requests and `load`.
- `frame_start`  in  1  synchronous one-cycle pulse at vsync; restarts the frame.
- `full`  in  1  buffer holds a word.
- `watermark_on`  in  1  buffer below its refill watermark.
- `data`  out  BSIZE*8  packed word; first fetched byte in bits [BSIZE*8-1 : (BSIZE-1)*8].
- `load`  out  1  one-cycle strobe; `data` is valid while high.
- `mem_rd`  out  1  one-cycle read request pulse.
- `mem_addr`  out  ADDR_W  byte address; held stable from `mem_rd` until the matching valid.
- `mem_rdata`  in  8  read data.
- `mem_rdata_valid`  in  1  one-cycle response; arrives ≥1 cycle after `mem_rd`.
- `frame_done`  out  1  one-cycle pulse when the last frame byte is accepted.

## Operation
- FSM states: IDLE, REQ, WAIT, LOAD, DRAIN.
- IDLE: when `en` && (!`full` || `watermark_on`), go to REQ. Otherwise stay in IDLE.
- REQ: assert `mem_rd` for one cycle, then go to WAIT.
- WAIT: on `mem_rdata_valid`:
  - Shift the byte into the pack register (left shift by 8, new byte in the LSB slice).
  - Increment `byte_cnt` and `mem_addr`.
  - If `byte_cnt` = BSIZE-1, go to LOAD. Otherwise go to REQ.
- LOAD: copy the pack register to `data` and pulse `load`. Clear `byte_cnt`. Go to IDLE.
  - If `en` is low, hold in LOAD and hold `load` low until `en` returns high.
- Address arithmetic: `mem_addr` = FRAME_BYTES-1 followed by a valid wraps to 0 and pulses `frame_done` in that cycle. The pack continues across the wrap.
- `frame_start` in IDLE, REQ or LOAD:
  - Discard the partial pack and set `mem_addr`=0 and `byte_cnt`=0.
  - Drop any pending load.
  - Go to IDLE.
- `frame_start` in WAIT: go to DRAIN. DRAIN absorbs and discards the outstanding valid, then goes to IDLE with `mem_addr`=0. Only one request is ever outstanding.
- `frame_start` coincident with `mem_rdata_valid`: discard the byte, set `mem_addr`=0, go to IDLE. `frame_done` is suppressed.
- `en` low during WAIT: the outstanding byte is still accepted. No new REQ is issued until `en` is high.
- `mem_rdata_valid` in any state other than WAIT or DRAIN is a protocol error and is ignored.
- `data` holds its last value between loads.
- Reset values:
  - state=IDLE
  - `data`=0, `load`=0, `mem_rd`=0, `mem_addr`=0, `frame_done`=0
  - internal `byte_cnt`=0, pack register=0

## Timing
- All outputs are registered.
- `full`/`watermark_on` are sampled in IDLE only. The buffer updates them on the same edge that captures `load`, so IDLE sees post-load flags.
- Memory latency L (cycles from `mem_rd` to valid): each byte costs 1+L cycles.
- Trigger sampled at edge n: `mem_rd` high in cycle n+1.
- With L=1 and BSIZE=2, `load` is high in cycle n+5. In general, `load` is high in cycle n+1+BSIZE·(1+L).
- Back-to-back words: at least one IDLE cycle separates `load` from the next `mem_rd`.
- Asserting `rst` mid-fetch returns the block to reset values immediately. A response arriving after reset is ignored (state=IDLE).

## Structure
- Shared package `video_pkg`:
  - `SLICE_WIDTH`=8
  - the `fetch_state_t` enum
  - `FRAME_BYTES` default
- Sub-module `fetch_addr_gen`: wrapping address counter with inc, clear and `frame_done` ports. Used for `mem_addr`; the FSM and pack register stay in the top level.

## Test plan
- Reset, then `full`=0 with a 1-cycle-latency memory returning 0xA5, 0x3C → `mem_addr` 0 then 1; `data`=0xA53C; `load` high exactly 5 cycles after the first IDLE sample.
- `full`=1, `watermark_on`=0 held for 50 cycles → no `mem_rd`, `load` stays 0. Then `watermark_on`=1 → fetch starts the next cycle.
- Start at `mem_addr`=FRAME_BYTES-1 → that byte is accepted, `frame_done` pulses once, the next request has address 0, and the pack completes across the wrap.
- `frame_start` during WAIT with L=4 → state enters DRAIN, the late valid is discarded, no `load` occurs, and the next `mem_rd` has address 0.
- `en` dropped for 10 cycles while in LOAD → `load` withheld, then a single `load` with unchanged `data` once `en` returns high.
- `rst` pulsed mid-WAIT → all outputs 0 immediately; the stray valid afterwards is ignored and the next fetch starts at address 0.
